// File: rtl/sprite_capture_pkg.sv
// Shared graphics definitions for the sprite capture path: coordinate and
// sprite geometry defaults, RAM address width helper and FSM state type.
package sprite_capture_pkg;

  localparam int CORDW_DEF      = 16;
  localparam int SPR_WIDTH_DEF  = 8;
  localparam int SPR_HEIGHT_DEF = 8;
  localparam int SPR_SCALE_DEF  = 0;
  localparam int SPR_DATAW_DEF  = 1;

  // Address width for a bitmap of n pixels; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    FINISH
  } cap_state_t;

endpackage

// File: rtl/sprite_capture_window.sv
// Signed window test: offset of (sx,sy) from the window origin, in-window
// check against the scaled sprite size, and decimation on the low bits.
// Outputs the bitmap column/row of the sample point.
module capture_window import sprite_capture_pkg::*; #(
  parameter int CORDW      = CORDW_DEF,
  parameter int SPR_WIDTH  = SPR_WIDTH_DEF,
  parameter int SPR_HEIGHT = SPR_HEIGHT_DEF,
  parameter int SPR_SCALE  = SPR_SCALE_DEF
) (
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] ox,
  input  logic signed [CORDW-1:0] oy,
  output logic                    hit,
  output logic        [CORDW-1:0] col,
  output logic        [CORDW-1:0] row
);

  localparam logic signed [CORDW-1:0] XLIM  = CORDW'(SPR_WIDTH << SPR_SCALE);
  localparam logic signed [CORDW-1:0] YLIM  = CORDW'(SPR_HEIGHT << SPR_SCALE);
  // Zero mask at scale 0, so the decimation test drops out naturally.
  localparam logic        [CORDW-1:0] LMASK = CORDW'((1 << SPR_SCALE) - 1);

  logic signed [CORDW-1:0] dx;
  logic signed [CORDW-1:0] dy;

  // Offsets, signed bounds check (negative offsets never hit) and decimation.
  always_comb begin
    dx  = sx - ox;
    dy  = sy - oy;
    hit = !dx[CORDW-1] && (dx < XLIM) &&
          !dy[CORDW-1] && (dy < YLIM) &&
          ((dx & LMASK) == '0) && ((dy & LMASK) == '0);
    col = dx >>> SPR_SCALE;
    row = dy >>> SPR_SCALE;
  end

endmodule

// File: rtl/sprite_capture.sv
// Raster-to-bitmap capture: on arm, waits for the next frame start and
// writes a rectangular (optionally decimated) window of the pixel stream
// into sprite RAM in row-major order, then pulses done.
module sprite_capture import sprite_capture_pkg::*; #(
  parameter  int CORDW      = CORDW_DEF,
  parameter  int SPR_WIDTH  = SPR_WIDTH_DEF,
  parameter  int SPR_HEIGHT = SPR_HEIGHT_DEF,
  parameter  int SPR_SCALE  = SPR_SCALE_DEF,
  parameter  int SPR_DATAW  = SPR_DATAW_DEF,
  localparam int ADDRW      = addr_width(SPR_WIDTH * SPR_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    frame,
  input  logic                    line,
  input  logic                    de,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] capx,
  input  logic signed [CORDW-1:0] capy,
  input  logic    [SPR_DATAW-1:0] pix_in,
  output logic                    busy,
  output logic                    done,
  output logic                    incomplete,
  output logic                    we,
  output logic        [ADDRW-1:0] waddr,
  output logic    [SPR_DATAW-1:0] wdata
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SPR_WIDTH * SPR_HEIGHT - 1);

  cap_state_t              state, state_n;
  logic signed [CORDW-1:0] capx_r, capy_r, capx_n, capy_n;
  logic                    we_n, done_n, inc_n;
  logic        [ADDRW-1:0] waddr_n, addr_calc;
  logic    [SPR_DATAW-1:0] wdata_n;
  logic                    win_hit, sample, last;
  logic        [CORDW-1:0] col, row;

  // line carries no state for this block.
  logic unused_line;
  assign unused_line = line;

  capture_window #(
    .CORDW      (CORDW),
    .SPR_WIDTH  (SPR_WIDTH),
    .SPR_HEIGHT (SPR_HEIGHT),
    .SPR_SCALE  (SPR_SCALE)
  ) u_window (
    .sx  (sx),
    .sy  (sy),
    .ox  (capx_r),
    .oy  (capy_r),
    .hit (win_hit),
    .col (col),
    .row (row)
  );

  // done is registered one stage after FINISH, so busy must cover it too.
  assign busy = (state != IDLE) || done;

  // Sample qualification and row-major address of the current position.
  always_comb begin
    addr_calc = ADDRW'(row) * ADDRW'(SPR_WIDTH) + ADDRW'(col);
    sample    = (state == CAPTURE) && de && win_hit;
    last      = sample && (addr_calc == LAST_ADDR);
  end

  // Next-state and next-output logic; the final write beats a coincident frame.
  always_comb begin
    state_n = state;
    capx_n  = capx_r;
    capy_n  = capy_r;
    we_n    = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    done_n  = 1'b0;
    inc_n   = incomplete;
    case (state)
      IDLE: begin
        if (arm) begin
          capx_n  = capx;
          capy_n  = capy;
          inc_n   = 1'b0;
          state_n = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (sample) begin
          we_n    = 1'b1;
          waddr_n = addr_calc;
          wdata_n = pix_in;
        end
        if (last) begin
          inc_n   = 1'b0;
          state_n = FINISH;
        end else if (frame) begin
          we_n    = 1'b0;
          waddr_n = waddr;
          wdata_n = wdata;
          inc_n   = 1'b1;
          state_n = FINISH;
        end
      end
      FINISH: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      capx_r     <= '0;
      capy_r     <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      done       <= 1'b0;
      incomplete <= 1'b0;
    end else begin
      state      <= state_n;
      capx_r     <= capx_n;
      capy_r     <= capy_n;
      we         <= we_n;
      waddr      <= waddr_n;
      wdata      <= wdata_n;
      done       <= done_n;
      incomplete <= inc_n;
    end
  end

endmodule

// File: tb/tb_sprite_capture.sv
// Directed bench: two captures (scale 1x and 2x) watch one shared raster.
// Expected RAM writes and done pulses are queued when stimulus is driven
// and checked when the DUT produces them.
module tb_sprite_capture;

  localparam int HACT = 112;
  localparam int HBLK = 4;
  localparam int VACT = 64;

  logic clk = 1'b0;
  logic rst, frame, line, de, arm0, arm1;
  logic signed [15:0] sx, sy, capx0, capy0, capx1, capy1;
  logic [3:0] pix_in;
  logic busy0, done0, inc0, we0, busy1, done1, inc1, we1;
  logic [5:0] waddr0, waddr1;
  logic [3:0] wdata0, wdata1;

  always #5 clk = ~clk;

  sprite_capture #(
    .CORDW(16), .SPR_WIDTH(8), .SPR_HEIGHT(8), .SPR_SCALE(0), .SPR_DATAW(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .frame(frame), .line(line), .de(de),
    .sx(sx), .sy(sy), .capx(capx0), .capy(capy0), .pix_in(pix_in),
    .busy(busy0), .done(done0), .incomplete(inc0), .we(we0),
    .waddr(waddr0), .wdata(wdata0)
  );

  sprite_capture #(
    .CORDW(16), .SPR_WIDTH(8), .SPR_HEIGHT(8), .SPR_SCALE(1), .SPR_DATAW(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .arm(arm1), .frame(frame), .line(line), .de(de),
    .sx(sx), .sy(sy), .capx(capx1), .capy(capy1), .pix_in(pix_in),
    .busy(busy1), .done(done1), .incomplete(inc1), .we(we1),
    .waddr(waddr1), .wdata(wdata1)
  );

  typedef struct {
    bit is_done;
    int addr;
    int data;
    bit inc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ms[2], mcx[2], mcy[2];
  int wr_cnt[2], done_cnt[2], last_we_cyc[2];
  bit last_inc[2], prev_done[2];

  bit req_rst, req_arm0, req_arm1;
  int req_cx0, req_cy0, req_cx1, req_cy1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pix_at(input int x, input int y);
    return (x * 3 + y * 5) & 15;
  endfunction

  function automatic ev_t mk(input bit d, input int a, input int v, input bit inc);
    ev_t e;
    e.is_done = d; e.addr = a; e.data = v; e.inc = inc;
    return e;
  endfunction

  function automatic void qpush(input int i, input ev_t e);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of capture unit i (scale i) at the coming clock edge.
  task automatic model_edge(input int i, input bit r, input bit a, input int cx, input int cy,
                            input bit f, input bit d, input int x, input int y);
    int w, dx, dy, addr, st;
    bit hit;
    st = 1 << i;
    w  = 8 << i;
    if (r) begin
      ms[i] = 0;
      return;
    end
    case (ms[i])
      0: if (a) begin mcx[i] = cx; mcy[i] = cy; ms[i] = 1; end
      1: if (f) ms[i] = 2;
      2: begin
        dx   = x - mcx[i];
        dy   = y - mcy[i];
        hit  = d && dx >= 0 && dx < w && dy >= 0 && dy < w && (dx % st) == 0 && (dy % st) == 0;
        addr = (dy / st) * 8 + dx / st;
        if (hit && addr == 63) begin
          qpush(i, mk(0, addr, pix_at(x, y), 0));
          qpush(i, mk(1, 0, 0, 0));
          ms[i] = 3;
        end else if (f) begin
          qpush(i, mk(1, 0, 0, 1));
          ms[i] = 3;
        end else if (hit) begin
          qpush(i, mk(0, addr, pix_at(x, y), 0));
        end
      end
      default: ms[i] = 0;
    endcase
  endtask

  task automatic observe(input int i, input logic we, input logic [5:0] wa, input logic [3:0] wd,
                         input logic dn, input logic inc, input logic bz);
    ev_t e;
    string p;
    p = $sformatf("u%0d", i);
    if (prev_done[i]) chk({p, ".busy_after_done"}, {31'b0, bz}, 0);
    if (we === 1'b1) begin
      wr_cnt[i]++;
      last_we_cyc[i] = cyc;
      if (qsize(i) == 0) chk({p, ".write_expected"}, {31'b0, qsize(i) > 0}, 1);
      else begin
        e = qpop(i);
        chk({p, ".write_kind"}, {31'b0, e.is_done}, 0);
        chk({p, ".waddr"}, {26'b0, wa}, e.addr);
        chk({p, ".wdata"}, {28'b0, wd}, e.data);
      end
      if (i == 1 && wa == 6'd9) chk("u1.addr9_pixel_12_22", {28'b0, wd}, pix_at(12, 22));
    end
    if (dn === 1'b1) begin
      done_cnt[i]++;
      last_inc[i] = inc;
      chk({p, ".busy_in_done"}, {31'b0, bz}, 1);
      if (qsize(i) == 0) chk({p, ".done_expected"}, {31'b0, qsize(i) > 0}, 1);
      else begin
        e = qpop(i);
        chk({p, ".done_kind"}, {31'b0, e.is_done}, 1);
        chk({p, ".incomplete"}, {31'b0, inc}, {31'b0, e.inc});
        if (!e.inc) chk({p, ".done_after_last_we"}, cyc - last_we_cyc[i], 1);
      end
    end
    prev_done[i] = (dn === 1'b1);
  endtask

  always @(negedge clk) begin
    observe(0, we0, waddr0, wdata0, done0, inc0, busy0);
    observe(1, we1, waddr1, wdata1, done1, inc1, busy1);
  end

  // Drive one cycle of inputs right after a rising edge; model the next edge.
  task automatic tick(input bit f, input bit ln, input bit d, input int x, input int y);
    @(posedge clk);
    #1;
    rst = req_rst; frame = f; line = ln; de = d;
    sx = 16'(x); sy = 16'(y); pix_in = 4'(pix_at(x, y));
    arm0 = req_arm0; capx0 = 16'(req_cx0); capy0 = 16'(req_cy0);
    arm1 = req_arm1; capx1 = 16'(req_cx1); capy1 = 16'(req_cy1);
    model_edge(0, req_rst, req_arm0, req_cx0, req_cy0, f, d, x, y);
    model_edge(1, req_rst, req_arm1, req_cx1, req_cy1, f, d, x, y);
    req_rst = 0; req_arm0 = 0; req_arm1 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, -4, 0);
  endtask

  // Raster lines y0..y1-1: HBLK blank cycles then HACT active pixels each.
  task automatic run_lines(input int y0, input int y1, input bit fr);
    for (int y = y0; y < y1; y++)
      for (int xi = 0; xi < HBLK + HACT; xi++)
        tick(fr && y == 0 && xi == 0, xi == 0, xi >= HBLK, xi - HBLK, y);
  endtask

  initial begin
    rst = 1; frame = 0; line = 0; de = 0; sx = '0; sy = '0; pix_in = '0;
    arm0 = 0; arm1 = 0; capx0 = '0; capy0 = '0; capx1 = '0; capy1 = '0;
    req_rst = 0; req_arm0 = 0; req_arm1 = 0;
    req_cx0 = 0; req_cy0 = 0; req_cx1 = 0; req_cy1 = 0;
    for (int i = 0; i < 2; i++) begin
      ms[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0; last_we_cyc[i] = 0;
      last_inc[i] = 0; prev_done[i] = 0;
    end

    repeat (3) begin req_rst = 1; idle(1); end
    chk("reset.busy", {31'b0, busy0}, 0);
    chk("reset.done", {31'b0, done0}, 0);
    chk("reset.incomplete", {31'b0, inc0}, 0);
    chk("reset.we", {31'b0, we0}, 0);
    chk("reset.waddr", {26'b0, waddr0}, 0);
    chk("reset.wdata", {28'b0, wdata0}, 0);
    chk("reset.busy1", {31'b0, busy1}, 0);
    idle(2);

    // Frame A: 1x window at (100,50), 2x window at (10,20).
    req_arm0 = 1; req_cx0 = 100; req_cy0 = 50;
    req_arm1 = 1; req_cx1 = 10;  req_cy1 = 20;
    idle(2);
    chk("A.busy0_after_arm", {31'b0, busy0}, 1);
    chk("A.busy1_after_arm", {31'b0, busy1}, 1);
    run_lines(0, VACT, 1);
    chk("A.u0_writes", wr_cnt[0], 64);
    chk("A.u0_done_cnt", done_cnt[0], 1);
    chk("A.u0_incomplete", {31'b0, last_inc[0]}, 0);
    chk("A.u1_writes", wr_cnt[1], 64);
    chk("A.u1_done_cnt", done_cnt[1], 1);

    // Frame B: bottom-clipped window; u1 armed on the frame pulse itself.
    req_arm0 = 1; req_cx0 = 0; req_cy0 = 60;
    idle(1);
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    req_arm1 = 1; req_cx1 = 10; req_cy1 = 20;
    run_lines(0, VACT, 1);
    chk("B.u0_writes", wr_cnt[0], 32);
    chk("B.u1_no_writes", wr_cnt[1], 0);
    chk("B.u1_waiting", {31'b0, busy1}, 1);

    // Frame C: frame ends u0 incomplete; u1 captures, ignoring a mid-capture arm.
    run_lines(0, 32, 1);
    chk("C.u0_done_cnt", done_cnt[0], 2);
    chk("C.u0_incomplete", {31'b0, last_inc[0]}, 1);
    chk("C.u0_idle", {31'b0, busy0}, 0);
    req_arm0 = 1; req_cx0 = -3; req_cy0 = 60;
    req_arm1 = 1; req_cx1 = 50; req_cy1 = 5;
    run_lines(32, VACT, 0);
    chk("C.u1_writes", wr_cnt[1], 64);
    chk("C.u1_done_cnt", done_cnt[1], 2);
    chk("C.u1_incomplete", {31'b0, last_inc[1]}, 0);

    // Frame D: window at (-3,60): only columns 3..7 of rows 0..3 written.
    wr_cnt[0] = 0;
    run_lines(0, VACT, 1);
    chk("D.u0_writes", wr_cnt[0], 20);
    run_lines(0, 8, 1);
    chk("D.u0_done_cnt", done_cnt[0], 3);
    chk("D.u0_incomplete", {31'b0, last_inc[0]}, 1);

    // Frame F: reset in the middle of a capture.
    req_arm0 = 1; req_cx0 = 100; req_cy0 = 50;
    run_lines(8, VACT, 0);
    wr_cnt[0] = 0;
    run_lines(0, 52, 1);
    chk("F.u0_partial_writes", wr_cnt[0], 16);
    chk("F.u0_busy", {31'b0, busy0}, 1);
    req_rst = 1;
    idle(2);
    chk("F.rst_busy", {31'b0, busy0}, 0);
    chk("F.rst_we", {31'b0, we0}, 0);
    idle(4);
    chk("F.rst_no_done", done_cnt[0], 3);

    // Frame G: re-arm after reset captures normally.
    req_arm0 = 1; req_cx0 = 100; req_cy0 = 50;
    idle(1);
    wr_cnt[0] = 0;
    run_lines(0, VACT, 1);
    chk("G.u0_writes", wr_cnt[0], 64);
    chk("G.u0_done_cnt", done_cnt[0], 4);
    chk("G.u0_incomplete", {31'b0, last_inc[0]}, 0);
    idle(4);
    chk("end.q0_drained", q0.size(), 0);
    chk("end.q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_capture.md
# sprite_capture

Raster-to-bitmap capture engine: watches the same screen-position stream (sx, sy, line, frame) that the sprite renderers consume, samples a rectangular window of the incoming pixel stream, and writes it into a sprite bitmap RAM in row-major order. It is the writer counterpart of the sprite renderer: bitmaps captured here are later read back by a sprite instance with matching SPR_WIDTH, SPR_HEIGHT, SPR_SCALE and SPR_DATAW. It sits between the display timing/pixel pipeline and the sprite RAM write port.

## Interface
- CORDW, 16, signed coordinate width (bits)
- SPR_WIDTH, 8, bitmap width in pixels
- SPR_HEIGHT, 8, bitmap height in pixels
- SPR_SCALE, 0, downsample factor: 0=1x, 1=every 2nd pixel/line, 2=every 4th, etc.
- SPR_DATAW, 1, bits per pixel

Ports (ADDRW = $clog2(SPR_WIDTH*SPR_HEIGHT)):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arm  in  1  single-cycle capture request
- frame  in  1  start-of-frame pulse
- line  in  1  start-of-active-line pulse (informational; no state change)
- de  in  1  pixel data valid at (sx,sy)
- sx, sy  in  CORDW signed  current screen position
- capx, capy  in  CORDW signed  window top-left, sampled on accepted arm
- pix_in  in  SPR_DATAW  pixel colour index at (sx,sy)
- busy  out  1  capture in progress
- done  out  1  one-cycle completion pulse
- incomplete  out  1  valid with done: 1 = frame ended before all writes
- we  out  1  RAM write enable
- waddr  out  ADDRW  RAM write address
- wdata  out  SPR_DATAW  RAM write data

## Operation
- States: IDLE, WAIT_FRAME, CAPTURE, FINISH.
- IDLE: arm=1 -> latch capx_r/capy_r, clear incomplete, go WAIT_FRAME. arm in any other state ignored.
- WAIT_FRAME: frame=1 -> CAPTURE. Capture never starts mid-frame.
- CAPTURE: each cycle compute dx = sx - capx_r, dy = sy - capy_r (CORDW signed). Sample when de && 0 <= dx < SPR_WIDTH<<SPR_SCALE && 0 <= dy < SPR_HEIGHT<<SPR_SCALE && dx[SPR_SCALE-1:0]==0 && dy[SPR_SCALE-1:0]==0 (low-bit test omitted when SPR_SCALE=0). On sample: we=1, waddr = (dy>>>SPR_SCALE)*SPR_WIDTH + (dx>>>SPR_SCALE), truncated to ADDRW; wdata = pix_in.
- Write of address SPR_WIDTH*SPR_HEIGHT-1 -> FINISH, incomplete=0.
- frame=1 while in CAPTURE (window partly/fully off-screen) -> FINISH with incomplete=1; no write that cycle.
- FINISH: done=1 for one cycle, -> IDLE.
- Arithmetic: dx/dy in CORDW signed; comparisons signed; negative offsets never sample.

## Timing
- Reset: state IDLE; busy, done, incomplete, we = 0; waddr = 0; wdata = 0.
- arm accepted at edge N -> busy=1 from cycle N+1.
- Write latency 1 cycle: inputs sampled at edge N appear on we/waddr/wdata during cycle N+1; we is a one-cycle strobe per sample.
- done asserted the cycle after the final we (or after the terminating frame); busy stays 1 through the done cycle, 0 the cycle after.
- frame coincident with arm in IDLE: arm accepted, frame ignored; capture starts at the next frame.
- Simultaneous last-pixel sample and frame: the write wins (complete capture, incomplete=0).
- rst mid-capture: immediate return to IDLE, no done pulse; partial RAM contents undefined.

## Structure
- Shared graphics package: CORDW default, sprite geometry defaults, ADDRW helper, state encoding constants.
- Single module; RAM external. Optional sub-module `capture_window` (signed in-window/offset/decimation test), reusable by the renderer.

## Test plan
- 8x8, scale 0, capx=100, capy=50, ramp pixel stream: arm, frame -> 64 writes, waddr 0..63 in raster order, wdata = pix at (100+i,50+j), done 1 cycle after write 63, incomplete=0.
- SPR_SCALE=1, capx=10, capy=20: writes only at even dx/dy in 16x16 region; waddr 9 = pixel (12,22).
- Window at capy=476 on 480-line screen -> 32 writes (addr 0..31), next frame -> done with incomplete=1.
- capx=-3: columns 0..2 never written; frame ends -> done, incomplete=1; no writes with negative offsets.
- arm during CAPTURE ignored; arm same cycle as frame in IDLE waits one full frame before writing.
- rst asserted mid-CAPTURE -> next cycle busy=0, we=0, no done; re-arm captures normally.
